// File: rtl/input_keypad_pkg.sv
// Shared key encodings, limits and frame-decode helper for the keypad entry block.
// The INPUT_KEYPAD_AUTOREPEAT_EN build option uses the repeat constants defined here.
package input_keypad_pkg;

  localparam logic [4:0] KEY_NONE  = 5'h10;
  localparam logic [3:0] KEY_NEG   = 4'd10;
  localparam logic [3:0] KEY_BKSP  = 4'd11;
  localparam logic [3:0] KEY_CLR   = 4'd12;
  localparam logic [3:0] KEY_ENTER = 4'd13;

  localparam int VALUE_MAX    = 127;
  localparam int REPEAT_FIRST = 32;
  localparam int REPEAT_NEXT  = 8;

  // Frame map bit index is col*4+row; the key code is row*4+col.
  function automatic logic [4:0] decode_frame(input logic [15:0] map);
    logic [4:0] code;
    int n;
    code = KEY_NONE;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (map[i]) begin
        n++;
        code = {1'b0, i[1:0], i[3:2]};
      end
    end
    return (n == 1) ? code : KEY_NONE;
  endfunction

endpackage

// File: rtl/input_keypad_scan.sv
// Keypad column scan, row synchronizer, frame decode and debounce producing single key events.
// Defining INPUT_KEYPAD_AUTOREPEAT_EN adds held-key repeat for digits, NEG and BKSP.
module input_keypad_scan
  import input_keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_FRAMES);

  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic [3:0]       row_s1, row_s2;
  logic [15:0]      map, map_next;
  logic [4:0]       prev_code, stable_code, frame_code, stable_next;
  logic [DB_W-1:0]  db_cnt, db_next;
  logic             sample, frame_done, press_evt, rep_evt;

  assign sample     = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_done = sample && (col == 2'd3);

  always_comb begin
    map_next = map;
    map_next[4*col +: 4] = ~row_s2;
  end

  assign frame_code  = decode_frame(map_next);
  assign db_next     = (frame_code != prev_code) ? DB_W'(1) :
                       (db_cnt == DB_MAX)        ? db_cnt   : db_cnt + DB_W'(1);
  assign stable_next = (db_next == DB_MAX) ? frame_code : stable_code;
  assign press_evt   = (stable_code == KEY_NONE) && (stable_next != KEY_NONE);

`ifdef INPUT_KEYPAD_AUTOREPEAT_EN
  logic [5:0] rep_cnt;
  logic       repeatable;

  assign repeatable = (stable_next <= {1'b0, KEY_BKSP});
  assign rep_evt    = (stable_next == stable_code) && repeatable &&
                      (rep_cnt == 6'(REPEAT_FIRST - 1));

  // After the first repeat the counter restarts so the next one is REPEAT_NEXT frames later.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rep_cnt <= '0;
    end else if (frame_done) begin
      if (stable_next != stable_code || !repeatable) rep_cnt <= '0;
      else if (rep_evt) rep_cnt <= 6'(REPEAT_FIRST - REPEAT_NEXT);
      else rep_cnt <= rep_cnt + 6'd1;
    end
  end
`else
  assign rep_evt = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div   <= '0;
      col   <= 2'd0;
      col_n <= 4'b1110;
      map   <= '0;
    end else if (sample) begin
      div   <= '0;
      col   <= col + 2'd1;
      col_n <= {col_n[2:0], col_n[3]};
      map   <= map_next;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      prev_code   <= KEY_NONE;
      stable_code <= KEY_NONE;
      db_cnt      <= '0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_done) begin
        prev_code   <= frame_code;
        db_cnt      <= db_next;
        stable_code <= stable_next;
        if (press_evt || rep_evt) begin
          key_code  <= stable_next[3:0];
          key_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/input_keypad_entry.sv
// Keypad entry top: accumulates a signed decimal operand, drives the display and commits on ENTER.
// Autorepeat is available via INPUT_KEYPAD_AUTOREPEAT_EN (handled inside the scan block).
module input_keypad_entry
  import input_keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [7:0] data_outH,
  output logic [7:0] data_outL,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [7:0] value,
  output logic       value_valid
);

  logic [6:0]  mag;
  logic        sign;
  logic        clr_pending;
  logic [10:0] digit_sum;
  logic [7:0]  entry;

  input_keypad_scan #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_scan (
    .Clock     (Clock),
    .Reset     (Reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  assign digit_sum = 11'(mag) * 11'd10 + 11'(key_code);
  assign entry     = sign ? (8'd0 - {1'b0, mag}) : {1'b0, mag};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mag         <= '0;
      sign        <= 1'b0;
      clr_pending <= 1'b0;
      value       <= '0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      // Committed entry is cleared one edge after the value is handed off.
      if (clr_pending) begin
        mag         <= '0;
        sign        <= 1'b0;
        clr_pending <= 1'b0;
      end
      if (key_valid) begin
        if (key_code <= 4'd9) begin
          if (digit_sum <= 11'(VALUE_MAX)) mag <= digit_sum[6:0];
        end else begin
          case (key_code)
            KEY_NEG:  sign <= ~sign;
            KEY_BKSP: begin
              mag <= mag / 7'd10;
              if (mag < 7'd10) sign <= 1'b0;
            end
            KEY_CLR: begin
              mag  <= '0;
              sign <= 1'b0;
            end
            KEY_ENTER: begin
              value       <= entry;
              value_valid <= 1'b1;
              clr_pending <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      data_outL <= '0;
      data_outH <= '0;
    end else begin
      data_outL <= entry;
      data_outH <= {8{entry[7]}};
    end
  end

endmodule

// File: tb/tb_input_keypad_entry.sv
// Directed bench for input_keypad_entry with a bouncing matrix keypad model (SCAN_DIV=4, DEBOUNCE_FRAMES=2).
module tb_input_keypad_entry;

  localparam int FRAME = 16;

  logic       Clock;
  logic       Reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [7:0] data_outH, data_outL;
  logic [3:0] key_code;
  logic       key_valid;
  logic [7:0] value;
  logic       value_valid;

  logic [15:0] pressed;
  int          kv_cnt, vv_cnt;
  logic [7:0]  last_value;
  int          n_tests, n_fail;

  input_keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .row_n       (row_n),
    .col_n       (col_n),
    .data_outH   (data_outH),
    .data_outL   (data_outL),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .value       (value),
    .value_valid (value_valid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Key k sits at row k/4, column k%4; a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_n[c] && pressed[r*4+c]) row_n[r] = 1'b0;
  end

  always @(posedge Clock) begin
    if (key_valid) kv_cnt <= kv_cnt + 1;
    if (value_valid) begin
      vv_cnt     <= vv_cnt + 1;
      last_value <= value;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge Clock);
    @(negedge Clock);
  endtask

  // One bounce frame, one open frame, a solid 3-frame press, then release.
  task automatic press_key(input int k);
    pressed = 16'h0;
    pressed[k] = 1'b1;
    clocks(FRAME);
    pressed = 16'h0;
    clocks(FRAME);
    pressed[k] = 1'b1;
    clocks(3 * FRAME);
    pressed = 16'h0;
    clocks(4 * FRAME);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    kv_cnt  = 0;
    vv_cnt  = 0;
    last_value = 8'h00;
    pressed = 16'h0;
    Reset   = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);

    check("rst_col_n", 32'(col_n), 32'h0E);
    check("rst_data_outL", 32'(data_outL), 32'h00);
    check("rst_data_outH", 32'(data_outH), 32'h00);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_value", 32'(value), 32'h00);
    check("rst_value_valid", 32'(value_valid), 32'h0);

    Reset = 1'b0;
    repeat (3) @(posedge Clock);
    #1 check("col_hold", 32'(col_n), 32'h0E);
    @(posedge Clock);
    #1 check("col_rot1", 32'(col_n), 32'h0D);
    repeat (4) @(posedge Clock);
    #1 check("col_rot2", 32'(col_n), 32'h0B);
    clocks(10 * FRAME);
    check("idle_key_valid_cnt", 32'(kv_cnt), 32'd0);
    check("idle_value_valid_cnt", 32'(vv_cnt), 32'd0);

    press_key(1);
    press_key(2);
    press_key(7);
    check("127_key_cnt", 32'(kv_cnt), 32'd3);
    check("127_data_outL", 32'(data_outL), 32'h7F);
    check("127_data_outH", 32'(data_outH), 32'h00);
    press_key(13);
    check("enter_key_cnt", 32'(kv_cnt), 32'd4);
    check("enter_key_code", 32'(key_code), 32'd13);
    check("enter_vv_cnt", 32'(vv_cnt), 32'd1);
    check("enter_value", 32'(last_value), 32'h7F);
    check("enter_cleared", 32'(data_outL), 32'h00);

    press_key(1);
    press_key(3);
    press_key(10);
    check("neg13_L", 32'(data_outL), 32'hF3);
    check("neg13_H", 32'(data_outH), 32'hFF);
    press_key(9);
    check("reject9_L", 32'(data_outL), 32'hF3);
    check("reject9_key_cnt", 32'(kv_cnt), 32'd8);
    check("reject9_key_code", 32'(key_code), 32'd9);

    press_key(12);
    check("clr_L", 32'(data_outL), 32'h00);
    press_key(5);
    press_key(10);
    check("neg5_L", 32'(data_outL), 32'hFB);
    press_key(11);
    check("bksp_L", 32'(data_outL), 32'h00);
    check("bksp_H", 32'(data_outH), 32'h00);
    press_key(4);
    check("four_L", 32'(data_outL), 32'h04);
    check("four_H", 32'(data_outH), 32'h00);
    check("four_key_cnt", 32'(kv_cnt), 32'd13);

    pressed = 16'h0088;
    clocks(5 * FRAME);
    pressed = 16'h0;
    clocks(4 * FRAME);
    check("ghost_key_cnt", 32'(kv_cnt), 32'd13);
    check("ghost_L", 32'(data_outL), 32'h04);

    pressed = 16'h0;
    pressed[8] = 1'b1;
    clocks(FRAME + 6);
    Reset = 1'b1;
    #1;
    check("midrst_col_n", 32'(col_n), 32'h0E);
    check("midrst_L", 32'(data_outL), 32'h00);
    check("midrst_value", 32'(value), 32'h00);
    check("midrst_key_code", 32'(key_code), 32'h0);
    clocks(3);
    pressed = 16'h0;
    Reset = 1'b0;
    clocks(6 * FRAME);
    check("postrst_key_cnt", 32'(kv_cnt), 32'd13);
    press_key(8);
    check("press8_key_cnt", 32'(kv_cnt), 32'd14);
    check("press8_key_code", 32'(key_code), 32'd8);
    check("press8_L", 32'(data_outL), 32'h08);
    check("final_vv_cnt", 32'(vv_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
